// File: rtl/ar429_pkg.sv
// ar429_pkg -- shared definitions for the ARINC-429 transmitter slice.
//   AR_WORD_BITS / AR_LBL_W / AR_DAT_W : word, label and data field widths
//   ar_state_e                         : transmitter FSM states
//   half_cnt()                         : clk cycles per half bit for a given rate
//   ar_rev_dat()                       : bit-reverse of the data field (line order is dat[0] first)
package ar429_pkg;

    localparam int AR_WORD_BITS = 32;
    localparam int AR_LBL_W     = 8;
    localparam int AR_DAT_W     = 23;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } ar_state_e;

    function automatic int half_cnt(input int clk_hz, input int rate);
        return clk_hz / (2 * rate);
    endfunction

    function automatic logic [AR_DAT_W-1:0] ar_rev_dat(input logic [AR_DAT_W-1:0] d);
        logic [AR_DAT_W-1:0] r;
        for (int i = 0; i < AR_DAT_W; i++) begin
            r[i] = d[AR_DAT_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ar_txd_if.sv
// ar_txd_if -- word request / line side bundle of the ARINC-429 transmitter.
//   adr[7:0]  label, MSB first on the line
//   dat[22:0] data field, dat[0] first on the line
//   st        one-clk start strobe
//   sel_lo    rate select (1 = low speed), sampled with st
//   TXD1/TXD0 bipolar RZ line pair
//   busy      word or gap in progress
//   done      one-clk pulse at the end of the gap
// master = word source, slave = transmitter.
interface ar_txd_if;
    import ar429_pkg::*;

    logic [AR_LBL_W-1:0] adr;
    logic [AR_DAT_W-1:0] dat;
    logic                st;
    logic                sel_lo;
    logic                TXD1;
    logic                TXD0;
    logic                busy;
    logic                done;

    modport master (
        output adr, dat, st, sel_lo,
        input  TXD1, TXD0, busy, done
    );

    modport slave (
        input  adr, dat, st, sel_lo,
        output TXD1, TXD0, busy, done
    );
endinterface

// File: rtl/ar_bit_timer.sv
// ar_bit_timer -- half-bit tick generator.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count while high; counter and phase held at 0 while low
//   sel_lo   : 1 selects the low-speed half period
//   tick     : high in the last clk of each half bit
//   phase    : 0 = active half, 1 = null half
module ar_bit_timer
    import ar429_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int RATE_HI = 100_000,
    parameter int RATE_LO = 12_500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sel_lo,
    output logic tick,
    output logic phase
);
    localparam int HALF_HI  = half_cnt(CLK_HZ, RATE_HI);
    localparam int HALF_LO  = half_cnt(CLK_HZ, RATE_LO);
    localparam int HALF_MAX = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI;
    localparam int CW       = $clog2(HALF_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last;
    logic          phase_q, phase_d;

    assign last  = sel_lo ? CW'(HALF_LO - 1) : CW'(HALF_HI - 1);
    assign tick  = en && (cnt_q == last);
    assign phase = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end
endmodule

// File: rtl/ar_txd.sv
// ar_txd -- ARINC-429 word transmitter (bipolar RZ, odd parity, null gap).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ar_txd_if.slave -- adr/dat/st/sel_lo in, TXD1/TXD0/busy/done out
// Line order: adr[7..0], dat[0..22], parity. Each bit is HALF clk active
// followed by HALF clk null; the word is followed by GAP_BITS null bits.
module ar_txd
    import ar429_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int RATE_HI  = 100_000,
    parameter int RATE_LO  = 12_500,
    parameter int GAP_BITS = 4
) (
    input  logic    clk,
    input  logic    rst,
    ar_txd_if.slave bus
);
    localparam int GAP_W = $clog2(2 * GAP_BITS);

    ar_state_e               state_q, state_d;
    logic [AR_WORD_BITS-1:0] sr_q, sr_d;
    logic [5:0]              idx_q, idx_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    sel_q, sel_d;
    logic                    txd1_q, txd1_d;
    logic                    txd0_q, txd0_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tick, phase;
    logic                    parity;

    ar_bit_timer #(
        .CLK_HZ  (CLK_HZ),
        .RATE_HI (RATE_HI),
        .RATE_LO (RATE_LO)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q != IDLE),
        .sel_lo (sel_q),
        .tick   (tick),
        .phase  (phase)
    );

    // Odd parity: total number of ones over the 32-bit word is odd.
    assign parity = ~^{bus.adr, bus.dat};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        sel_d   = sel_q;
        txd1_d  = 1'b0;
        txd0_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.st) begin
                    // Shift register is MSB-first, so the data field is stored reversed.
                    sr_d    = {bus.adr, ar_rev_dat(bus.dat), parity};
                    sel_d   = bus.sel_lo;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    txd1_d  = bus.adr[AR_LBL_W-1];
                    txd0_d  = ~bus.adr[AR_LBL_W-1];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!tick) begin
                    txd1_d = txd1_q;
                    txd0_d = txd0_q;
                end else if (phase) begin
                    // End of a null half: start the next bit or move into the gap.
                    if (idx_q == 6'(AR_WORD_BITS - 1)) begin
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        idx_d  = idx_q + 6'd1;
                        sr_d   = {sr_q[AR_WORD_BITS-2:0], 1'b0};
                        txd1_d = sr_q[AR_WORD_BITS-2];
                        txd0_d = ~sr_q[AR_WORD_BITS-2];
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q == GAP_W'(2 * GAP_BITS - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            sel_q   <= 1'b0;
            txd1_q  <= 1'b0;
            txd0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            txd1_q  <= txd1_d;
            txd0_q  <= txd0_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Word payload needs no reset: it is always loaded before it is shifted out.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign bus.TXD1 = txd1_q;
    assign bus.TXD0 = txd0_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    a_lines_exclusive: assert property (@(posedge clk) disable iff (rst) !(txd1_q && txd0_q));
endmodule
